shader_sequencer: RTL and testbench
===================================

Name: shader_sequencer

Overview:
Per-pixel instruction scheduler for the shader core. It walks the shader memory program counter once for each pixel slot from the VGA timing block and qualifies fetched instructions to the execute unit. It also arbitrates the single shader memory port between instruction fetch and the SPI loader's write requests. It sits between the SPI loader, shader memory, shader execute and VGA timing inside the tiny shader top.

Parameters:
NUM_INSTR, 16, shader memory depth in instructions (power of two, >= 2)
INSTR_W, 8, instruction width in bits
ADDR_W, 4, memory address width, equal to log2(NUM_INSTR)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pause_i  in  1  freeze execution; sampled at pixel_start_i
double_instr_i  in  1  0: program length NUM_INSTR/2; 1: program length NUM_INSTR; sampled at pixel_start_i
half_res_i  in  1  1: execute only on even pixel slots
pixel_start_i  in  1  one-cycle pulse at the start of each active pixel slot
line_start_i  in  1  one-cycle pulse at the start of each line; resets the half-res phase
wr_req_i  in  1  SPI loader write request, held until acknowledged
wr_addr_i  in  ADDR_W  write address
wr_data_i  in  INSTR_W  write data
wr_ack_o  out  1  one-cycle write acknowledge
mem_addr_o  out  ADDR_W  shader memory address
mem_re_o  out  1  memory read enable
mem_we_o  out  1  memory write enable
mem_wdata_o  out  INSTR_W  memory write data
exec_init_o  out  1  one-cycle pulse that clears the execute registers for a new pixel
instr_valid_o  out  1  memory read data is a valid instruction this cycle
pixel_done_o  out  1  one-cycle pulse when the pixel result is final
overrun_o  out  1  sticky flag: pixel_start_i arrived while in RUN

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE, pc = 0, half-res phase = 0, program length latch = NUM_INSTR/2.
- States:
  - IDLE
  - RUN
  - DRAIN: one cycle in which the last read completes.
- Memory has a 1-cycle read latency. mem_re_o at cycle t gives valid data at t+1, and instr_valid_o = mem_re_o delayed by one cycle.
- IDLE + pixel_start_i at cycle T:
  - Latch length L: NUM_INSTR/2 if double_instr_i = 0, else NUM_INSTR.
  - Toggle the phase.
  - If pause_i = 1: no action, and no pixel_done_o.
  - Else if half_res_i = 1 and phase was 1 (odd slot): pulse pixel_done_o at T+1 and do not execute. The execute unit keeps its previous colour.
  - Otherwise: pulse exec_init_o at T+1 and enter RUN.
- RUN:
  - Cycle T+1+k (k = 0..L-1): mem_re_o = 1, mem_addr_o = k.
  - After k = L-1, go to DRAIN.
  - instr_valid_o is high for cycles T+2 .. T+1+L.
- DRAIN: pixel_done_o pulses at T+2+L, then IDLE. Total latency from pixel_start_i to pixel_done_o is L+2 cycles.
- line_start_i clears the phase to 0. If it coincides with pixel_start_i, that slot counts as even.
- Write arbitration:
  - Writes are granted only in IDLE and only in a cycle without pixel_start_i; fetch has priority.
  - On grant in the same cycle: mem_we_o = 1, mem_addr_o = wr_addr_i, mem_wdata_o = wr_data_i, wr_ack_o = 1.
  - One write per cycle, back-to-back allowed.
  - mem_we_o and mem_re_o are never high together.
- pixel_start_i in RUN or DRAIN: ignored, overrun_o set to 1. It is cleared only by reset.
- pause_i changes in RUN have no effect until the next pixel_start_i.
- While paused, all SPI writes are granted, so programs load without tearing.
- Reset mid-RUN: all outputs drop to 0 immediately (asynchronous), and no pixel_done_o is emitted.
- pc is ADDR_W bits wide; L = NUM_INSTR wraps to 0 exactly at the end, and the compare uses L-1.

Decomposition:
- Shared package shader_pkg holds:
  - state enum (IDLE, RUN, DRAIN)
  - NUM_INSTR, INSTR_W, ADDR_W
  - a function computing L from double_instr
- One natural sub-module, shader_mem_arbiter: combinational port mux plus the grant/ack logic. The FSM and counters stay in shader_sequencer.

Test Plan:
1. Reset, double_instr=0, pixel_start at cycle 10 -> exec_init at 11; mem_addr 0..7 at 11..18; instr_valid 12..19; pixel_done at 20; overrun=0.
2. double_instr=1, pixel_start at 10 -> mem_addr 0..15 at 11..26; pixel_done at 28.
3. half_res=1, line_start then four pixel_starts spaced 30 cycles -> slots 0 and 2 run full sequences; slots 1 and 3 give pixel_done 1 cycle after pixel_start with no mem_re and no exec_init.
4. wr_req (addr 5, data 0xA3) raised during RUN -> wr_ack stays 0 until IDLE; then mem_we=1, addr=5, data=0xA3, ack in the first IDLE cycle. wr_req coincident with pixel_start in IDLE -> ack deferred past the run.
5. pause=1 at pixel_start, 8 writes streamed -> 8 consecutive acks, no mem_re, no pixel_done; clear pause -> next pixel_start runs normally.
6. pixel_start during RUN -> overrun=1 and stays 1, current run completes unchanged; rst_n low mid-RUN -> all outputs 0 asynchronously, no pixel_done after release.

Source files
------------

// File: rtl/shader_pkg.sv
// Shared types and sizing for the shader sequencer slice.
package shader_pkg;
  localparam int NUM_INSTR = 16;
  localparam int INSTR_W   = 8;
  localparam int ADDR_W    = $clog2(NUM_INSTR);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;

  // Program length L; one extra bit so L = NUM_INSTR is representable.
  function automatic logic [ADDR_W:0] prog_len(input logic double_instr);
    return double_instr ? (ADDR_W+1)'(NUM_INSTR) : (ADDR_W+1)'(NUM_INSTR/2);
  endfunction
endpackage

// File: rtl/shader_sequencer_if.sv
// SPI-loader write channel and shader memory port as seen by the sequencer.
interface shader_sequencer_if;
  import shader_pkg::*;
  logic               wr_req_i;
  logic [ADDR_W-1:0]  wr_addr_i;
  logic [INSTR_W-1:0] wr_data_i;
  logic               wr_ack_o;
  logic [ADDR_W-1:0]  mem_addr_o;
  logic               mem_re_o;
  logic               mem_we_o;
  logic [INSTR_W-1:0] mem_wdata_o;

  modport master (
    input  wr_req_i, wr_addr_i, wr_data_i,
    output wr_ack_o, mem_addr_o, mem_re_o, mem_we_o, mem_wdata_o
  );
  modport slave (
    output wr_req_i, wr_addr_i, wr_data_i,
    input  wr_ack_o, mem_addr_o, mem_re_o, mem_we_o, mem_wdata_o
  );
endinterface

// File: rtl/shader_mem_arbiter.sv
// Single shader memory port mux: fetch owns it outside IDLE, SPI writes get idle cycles.
module shader_mem_arbiter
  import shader_pkg::*;
(
  input  logic               i_rst_n,
  input  logic               i_idle,
  input  logic               i_pixel_start,
  input  logic               i_fetch_re,
  input  logic [ADDR_W-1:0]  i_fetch_addr,
  input  logic               i_wr_req,
  input  logic [ADDR_W-1:0]  i_wr_addr,
  input  logic [INSTR_W-1:0] i_wr_data,
  output logic               o_wr_ack,
  output logic               o_mem_re,
  output logic               o_mem_we,
  output logic [ADDR_W-1:0]  o_mem_addr,
  output logic [INSTR_W-1:0] o_mem_wdata
);
  logic w_grant;

  // A pixel_start cycle belongs to fetch even though the FSM is still IDLE.
  assign w_grant     = i_rst_n & i_idle & ~i_pixel_start & i_wr_req;
  assign o_wr_ack    = w_grant;
  assign o_mem_we    = w_grant;
  assign o_mem_re    = i_fetch_re & ~w_grant;
  assign o_mem_addr  = w_grant ? i_wr_addr : (i_fetch_re ? i_fetch_addr : '0);
  assign o_mem_wdata = w_grant ? i_wr_data : '0;
endmodule

// File: rtl/shader_sequencer.sv
// Per-pixel program walker: fetches L instructions per pixel slot and qualifies them to execute.
module shader_sequencer
  import shader_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pause_i,
  input  logic               double_instr_i,
  input  logic               half_res_i,
  input  logic               pixel_start_i,
  input  logic               line_start_i,
  shader_sequencer_if.master bus,
  output logic               exec_init_o,
  output logic               instr_valid_o,
  output logic               pixel_done_o,
  output logic               overrun_o
);
  state_e              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_pc, w_pc_nxt;
  logic [ADDR_W-1:0]   r_last, w_last_nxt;
  logic                r_phase, w_phase_nxt;
  logic                r_exec_init, w_exec_init_nxt;
  logic                r_done, w_done_nxt;
  logic                r_ovr, w_ovr_nxt;
  logic                r_valid;
  logic                w_idle, w_fetch_re, w_eff_phase;
  logic [ADDR_W:0]     w_len;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_fetch_re  = (r_state == ST_RUN);
  assign w_eff_phase = line_start_i ? 1'b0 : r_phase;
  assign w_len       = prog_len(double_instr_i);

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_last_nxt      = r_last;
    w_phase_nxt     = w_eff_phase;
    w_exec_init_nxt = 1'b0;
    w_done_nxt      = 1'b0;
    w_ovr_nxt       = r_ovr | (pixel_start_i & ~w_idle);
    case (r_state)
      ST_IDLE: begin
        if (pixel_start_i) begin
          w_last_nxt  = ADDR_W'(w_len - 1'b1);
          w_phase_nxt = ~w_eff_phase;
          // Odd half-res slots finish at once; execute keeps its last colour.
          if (!pause_i) begin
            if (half_res_i && w_eff_phase) begin
              w_done_nxt = 1'b1;
            end else begin
              w_exec_init_nxt = 1'b1;
              w_pc_nxt        = '0;
              w_state_nxt     = ST_RUN;
            end
          end
        end
      end
      ST_RUN: begin
        w_pc_nxt = r_pc + ADDR_W'(1);
        if (r_pc == r_last) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_pc        <= '0;
      r_last      <= ADDR_W'(NUM_INSTR/2 - 1);
      r_phase     <= 1'b0;
      r_exec_init <= 1'b0;
      r_done      <= 1'b0;
      r_ovr       <= 1'b0;
      r_valid     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_last      <= w_last_nxt;
      r_phase     <= w_phase_nxt;
      r_exec_init <= w_exec_init_nxt;
      r_done      <= w_done_nxt;
      r_ovr       <= w_ovr_nxt;
      r_valid     <= w_fetch_re;
    end
  end

  assign exec_init_o   = r_exec_init;
  assign instr_valid_o = r_valid;
  assign pixel_done_o  = r_done;
  assign overrun_o     = r_ovr;

  shader_mem_arbiter u_arb (
    .i_rst_n       (rst_n),
    .i_idle        (w_idle),
    .i_pixel_start (pixel_start_i),
    .i_fetch_re    (w_fetch_re),
    .i_fetch_addr  (r_pc),
    .i_wr_req      (bus.wr_req_i),
    .i_wr_addr     (bus.wr_addr_i),
    .i_wr_data     (bus.wr_data_i),
    .o_wr_ack      (bus.wr_ack_o),
    .o_mem_re      (bus.mem_re_o),
    .o_mem_we      (bus.mem_we_o),
    .o_mem_addr    (bus.mem_addr_o),
    .o_mem_wdata   (bus.mem_wdata_o)
  );
endmodule

// File: tb/tb_shader_sequencer.sv
// Directed bench for shader_sequencer: IDLE write-arbitration table plus per-pixel run sequences.
module tb_shader_sequencer;
  logic clk, rst_n;
  logic pause_i, double_instr_i, half_res_i, pixel_start_i, line_start_i;
  logic exec_init_o, instr_valid_o, pixel_done_o, overrun_o;
  int   total = 0;
  int   bad   = 0;
  bit   exp_ovr = 0;

  shader_sequencer_if bus();

  shader_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pause_i        (pause_i),
    .double_instr_i (double_instr_i),
    .half_res_i     (half_res_i),
    .pixel_start_i  (pixel_start_i),
    .line_start_i   (line_start_i),
    .bus            (bus),
    .exec_init_o    (exec_init_o),
    .instr_valid_o  (instr_valid_o),
    .pixel_done_o   (pixel_done_o),
    .overrun_o      (overrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         pse;
    bit         ps;
    bit         req;
    logic [3:0] a;
    logic [7:0] d;
    bit         e_ack;
    logic [3:0] e_addr;
    logic [7:0] e_wd;
  } vec_t;
  vec_t tv[6];

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(string nm, bit e_re, logic [3:0] e_addr, bit e_we, logic [7:0] e_wd,
                         bit e_ack, bit e_init, bit e_val, bit e_done, bit e_ov);
    chk({nm, ".re"},    32'(bus.mem_re_o),    32'(e_re));
    chk({nm, ".addr"},  32'(bus.mem_addr_o),  32'(e_addr));
    chk({nm, ".we"},    32'(bus.mem_we_o),    32'(e_we));
    chk({nm, ".wdata"}, 32'(bus.mem_wdata_o), 32'(e_wd));
    chk({nm, ".ack"},   32'(bus.wr_ack_o),    32'(e_ack));
    chk({nm, ".init"},  32'(exec_init_o),     32'(e_init));
    chk({nm, ".valid"}, 32'(instr_valid_o),   32'(e_val));
    chk({nm, ".done"},  32'(pixel_done_o),    32'(e_done));
    chk({nm, ".ovr"},   32'(overrun_o),       32'(e_ov));
  endtask

  // mode 0: full run, 1: odd half-res skip, 2: paused. c counts cycles from pixel_start.
  task automatic do_pixel(string nm, bit dbl, bit half, bit pse, bit ls, int mode,
                          int wr_from, int ovr_at);
    int   L;
    int   n;
    bit   pend;
    bit   e_re, e_init, e_val, e_done, e_ack, idle;
    logic [3:0] e_addr;
    logic [7:0] e_wd;
    L = dbl ? 16 : 8;
    n = (mode == 0) ? L + 3 : 3;
    pend = 0;
    double_instr_i = dbl;
    half_res_i     = half;
    pause_i        = pse;
    for (int c = 0; c <= n; c++) begin
      pixel_start_i = (c == 0) || (c == ovr_at);
      line_start_i  = (c == 0) && ls;
      if (c == wr_from) pend = 1;
      bus.wr_req_i  = pend;
      bus.wr_addr_i = 4'd5;
      bus.wr_data_i = 8'hA3;
      @(negedge clk);
      e_re = 0; e_init = 0; e_val = 0; e_done = 0; e_addr = 4'd0; e_wd = 8'd0;
      if (mode == 0) begin
        e_init = (c == 1);
        e_re   = (c >= 1) && (c <= L);
        e_addr = e_re ? 4'(c - 1) : 4'd0;
        e_val  = (c >= 2) && (c <= L + 1);
        e_done = (c == L + 2);
        idle   = (c >= L + 2);
      end else begin
        e_done = (mode == 1) && (c == 1);
        idle   = (c >= 1);
      end
      e_ack = pend && idle && !pixel_start_i;
      if (e_ack) begin
        e_addr = 4'd5;
        e_wd   = 8'hA3;
      end
      chk_all($sformatf("%s c%0d", nm, c), e_re, e_addr, e_ack, e_wd, e_ack,
              e_init, e_val, e_done, exp_ovr);
      if (e_ack) pend = 0;
      if (c == ovr_at && c > 0) exp_ovr = 1;
      nxt();
    end
    pixel_start_i = 0;
    line_start_i  = 0;
    bus.wr_req_i  = 0;
  endtask

  initial begin
    rst_n = 0;
    pause_i = 0; double_instr_i = 0; half_res_i = 0;
    pixel_start_i = 0; line_start_i = 0;
    bus.wr_req_i = 0; bus.wr_addr_i = '0; bus.wr_data_i = '0;

    tv[0] = '{pse:0, ps:0, req:1, a:4'd5, d:8'hA3, e_ack:1, e_addr:4'd5, e_wd:8'hA3};
    tv[1] = '{pse:0, ps:0, req:1, a:4'hF, d:8'hFF, e_ack:1, e_addr:4'hF, e_wd:8'hFF};
    tv[2] = '{pse:0, ps:0, req:0, a:4'd3, d:8'h11, e_ack:0, e_addr:4'd0, e_wd:8'h00};
    tv[3] = '{pse:1, ps:1, req:1, a:4'd7, d:8'h5A, e_ack:0, e_addr:4'd0, e_wd:8'h00};
    tv[4] = '{pse:1, ps:0, req:1, a:4'd0, d:8'h00, e_ack:1, e_addr:4'd0, e_wd:8'h00};
    tv[5] = '{pse:0, ps:0, req:1, a:4'd9, d:8'hC3, e_ack:1, e_addr:4'd9, e_wd:8'hC3};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all("reset", 0, 4'd0, 0, 8'd0, 0, 0, 0, 0, 0);
    nxt();
    rst_n = 1;
    repeat (8) nxt();

    do_pixel("run8", 0, 0, 0, 0, 0, -1, -1);
    repeat (2) nxt();
    do_pixel("run16", 1, 0, 0, 0, 0, -1, -1);

    // Write arbitration in IDLE; the paused pixel_start row blocks its own cycle only.
    foreach (tv[i]) begin
      pause_i       = tv[i].pse;
      pixel_start_i = tv[i].ps;
      bus.wr_req_i  = tv[i].req;
      bus.wr_addr_i = tv[i].a;
      bus.wr_data_i = tv[i].d;
      @(negedge clk);
      chk_all($sformatf("tv%0d", i), 0, tv[i].e_addr, tv[i].e_ack, tv[i].e_wd, tv[i].e_ack,
              0, 0, 0, exp_ovr);
      nxt();
    end
    pause_i = 0; pixel_start_i = 0; bus.wr_req_i = 0;
    nxt();

    // Half-res: phase cleared by line_start; a coincident line_start makes the slot even.
    line_start_i = 1;
    nxt();
    line_start_i = 0;
    nxt();
    do_pixel("hr_s0", 0, 1, 0, 0, 0, -1, -1);
    repeat (4) nxt();
    do_pixel("hr_ls", 0, 1, 0, 1, 0, -1, -1);
    repeat (4) nxt();
    do_pixel("hr_s1", 0, 1, 0, 0, 1, -1, -1);
    repeat (4) nxt();
    do_pixel("hr_s2", 0, 1, 0, 0, 0, -1, -1);
    repeat (4) nxt();
    do_pixel("hr_s3", 0, 1, 0, 0, 1, -1, -1);
    half_res_i = 0;
    nxt();

    do_pixel("wr_run", 0, 0, 0, 0, 0, 3, -1);
    nxt();
    do_pixel("wr_coinc", 0, 0, 0, 0, 0, 0, -1);
    nxt();

    do_pixel("paused", 0, 0, 1, 0, 2, -1, -1);
    for (int i = 0; i < 8; i++) begin
      bus.wr_req_i  = 1;
      bus.wr_addr_i = 4'(i);
      bus.wr_data_i = 8'h10 + 8'(i);
      @(negedge clk);
      chk_all($sformatf("stream%0d", i), 0, 4'(i), 1, 8'h10 + 8'(i), 1, 0, 0, 0, exp_ovr);
      nxt();
    end
    bus.wr_req_i = 0;
    pause_i = 0;
    nxt();
    do_pixel("unpaused", 0, 0, 0, 0, 0, -1, -1);

    do_pixel("overrun", 0, 0, 0, 0, 0, -1, 4);
    repeat (3) begin
      @(negedge clk);
      chk("ovr_sticky", 32'(overrun_o), 32'(1));
      nxt();
    end

    // Asynchronous reset in the middle of a run.
    pixel_start_i = 1;
    nxt();
    pixel_start_i = 0;
    nxt();
    nxt();
    rst_n = 0;
    exp_ovr = 0;
    #1;
    chk_all("async_rst", 0, 4'd0, 0, 8'd0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk_all("in_rst", 0, 4'd0, 0, 8'd0, 0, 0, 0, 0, 0);
    nxt();
    rst_n = 1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d.done", i), 32'(pixel_done_o), 32'(0));
      chk($sformatf("post_rst%0d.re", i), 32'(bus.mem_re_o), 32'(0));
      nxt();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
